// File: rtl/cache_addr_subtractor_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_addr_subtractor_pipe_if
//  Description : Operand/result handshake bundle for the pipelined cache
//                address subtractor. The master side drives operands and
//                out_ready. The slave side (the subtractor) returns in_ready
//                and the result fields.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cache_addr_subtractor_pipe_if #(
    parameter int WIDTH = 12
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             borrow;
    logic             zero;
    logic             hit;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, z, borrow, zero, hit
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, z, borrow, zero, hit
    );
endinterface
`default_nettype wire

// File: rtl/cache_addr_subtractor_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cache_addr_subtractor_pipe
//  Description : Pipelined z = x - y (x + ~y + 1) built from 4-bit
//                carry-lookahead nibble groups. The carry chain is split
//                over STAGES valid/ready register stages. The last stage also
//                registers the borrow, zero and cache-window hit flags.
//                WIDTH must be a multiple of 4. STAGES must divide WIDTH/4.
//                WINDOW must be a power of two below 2^WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_addr_subtractor_pipe #(
    parameter int WIDTH  = 12,
    parameter int STAGES = 1,
    parameter int WINDOW = 512
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    cache_addr_subtractor_pipe_if.slave bus
);

    localparam int NIB = WIDTH / 4;
    localparam int NPS = NIB / STAGES;
    localparam logic [WIDTH-1:0] c_window_limit = WIDTH'(WINDOW);

    // One 4-bit lookahead group: returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Keeps only the operand nibbles that later stages still need, so the
    // flops for bits that are already resolved can be trimmed away.
    function automatic logic [WIDTH-1:0] rem_mask(input int first_open);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < NIB; i++) begin
            m[4*i +: 4] = (i >= first_open) ? 4'hF : 4'h0;
        end
        return m;
    endfunction

    // Signals entering stage k. Index 0 comes from the ports, index k+1
    // comes from the registers of stage k.
    logic [WIDTH-1:0]  w_link_x  [STAGES];
    logic [WIDTH-1:0]  w_link_yn [STAGES];
    logic [WIDTH-1:0]  w_link_z  [STAGES];
    logic [STAGES-1:0] w_link_c;
    logic [STAGES-1:0] w_link_v;
    logic [STAGES-1:0] w_vld;
    logic [STAGES-1:0] w_adv;

    assign w_link_x[0]  = bus.x;
    assign w_link_yn[0] = ~bus.y;
    assign w_link_z[0]  = '0;
    assign w_link_c[0]  = 1'b1;
    assign w_link_v[0]  = bus.in_valid;

    // Stall chain. A stage moves when it is empty or when its consumer moves.
    always_comb begin
        logic a;
        a     = bus.out_ready;
        w_adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            a        = ~w_vld[k] | a;
            w_adv[k] = a;
        end
    end

    assign bus.in_ready = reset | w_adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * NPS;
        localparam int HI = (k + 1) * NPS;

        logic             v_q;
        logic             v_d;
        logic             w_load;
        logic             w_carry;
        logic [WIDTH-1:0] w_z;

        assign w_load   = w_adv[k] & w_link_v[k];
        assign w_vld[k] = v_q;

        // Resolve this stage's nibbles, rippling group carries nibble to nibble.
        always_comb begin
            w_carry = w_link_c[k];
            w_z     = w_link_z[k];
            for (int i = LO; i < HI; i++) begin
                {w_carry, w_z[4*i +: 4]} = cla4(w_link_x[k][4*i +: 4],
                                                w_link_yn[k][4*i +: 4], w_carry);
            end
        end

        // Valid bit follows upstream whenever the stage advances.
        always_comb begin
            v_d = w_adv[k] ? w_link_v[k] : v_q;
        end

        // Stage valid register.
        always_ff @(posedge clk) begin
            if (reset) v_q <= 1'b0;
            else       v_q <= v_d;
        end

        if (k == STAGES - 1) begin : g_last
            logic [WIDTH-1:0] z_q;
            logic [WIDTH-1:0] z_d;
            logic             borrow_q;
            logic             borrow_d;
            logic             zero_q;
            logic             zero_d;
            logic             hit_q;
            logic             hit_d;

            // Final result and flags. Hold while stalled or on a bubble.
            always_comb begin
                z_d      = z_q;
                borrow_d = borrow_q;
                zero_d   = zero_q;
                hit_d    = hit_q;
                if (w_load) begin
                    z_d      = w_z;
                    borrow_d = ~w_carry;
                    zero_d   = (w_z == '0);
                    hit_d    = w_carry & (w_z < c_window_limit);
                end
            end

            // Output registers drive the ports directly.
            always_ff @(posedge clk) begin
                if (reset) begin
                    z_q      <= '0;
                    borrow_q <= 1'b0;
                    zero_q   <= 1'b0;
                    hit_q    <= 1'b0;
                end else begin
                    z_q      <= z_d;
                    borrow_q <= borrow_d;
                    zero_q   <= zero_d;
                    hit_q    <= hit_d;
                end
            end

            assign bus.out_valid = v_q;
            assign bus.z         = z_q;
            assign bus.borrow    = borrow_q;
            assign bus.zero      = zero_q;
            assign bus.hit       = hit_q;
        end else begin : g_mid
            localparam logic [WIDTH-1:0] c_keep = rem_mask(HI);

            logic [WIDTH-1:0] z_q;
            logic [WIDTH-1:0] z_d;
            logic [WIDTH-1:0] x_q;
            logic [WIDTH-1:0] x_d;
            logic [WIDTH-1:0] yn_q;
            logic [WIDTH-1:0] yn_d;
            logic             carry_q;
            logic             carry_d;

            // Capture partial sum, the remaining operand bits and the carry.
            always_comb begin
                z_d     = z_q;
                x_d     = x_q;
                yn_d    = yn_q;
                carry_d = carry_q;
                if (w_load) begin
                    z_d     = w_z;
                    x_d     = w_link_x[k] & c_keep;
                    yn_d    = w_link_yn[k] & c_keep;
                    carry_d = w_carry;
                end
            end

            // Intermediate stage registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    z_q     <= '0;
                    x_q     <= '0;
                    yn_q    <= '0;
                    carry_q <= 1'b0;
                end else begin
                    z_q     <= z_d;
                    x_q     <= x_d;
                    yn_q    <= yn_d;
                    carry_q <= carry_d;
                end
            end

            assign w_link_x[k+1]  = x_q;
            assign w_link_yn[k+1] = yn_q;
            assign w_link_z[k+1]  = z_q;
            assign w_link_c[k+1]  = carry_q;
            assign w_link_v[k+1]  = v_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_addr_subtractor_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_addr_subtractor_pipe
//  Description : Directed self-checking bench for three configurations of
//                cache_addr_subtractor_pipe (12b/1 stage, 12b/3 stages,
//                16b/2 stages).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_addr_subtractor_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_addr_subtractor_pipe_if #(.WIDTH(12)) if_s1 ();
    cache_addr_subtractor_pipe_if #(.WIDTH(12)) if_s3 ();
    cache_addr_subtractor_pipe_if #(.WIDTH(16)) if_w16 ();

    cache_addr_subtractor_pipe #(.WIDTH(12), .STAGES(1), .WINDOW(512)) u_s1 (
        .clk(clk), .reset(rst), .bus(if_s1));
    cache_addr_subtractor_pipe #(.WIDTH(12), .STAGES(3), .WINDOW(512)) u_s3 (
        .clk(clk), .reset(rst), .bus(if_s3));
    cache_addr_subtractor_pipe #(.WIDTH(16), .STAGES(2), .WINDOW(512)) u_w16 (
        .clk(clk), .reset(rst), .bus(if_w16));

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] tx [8];
    logic [11:0] ty [8];
    logic [14:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result for the 12-bit, WINDOW=512 configuration: {borrow, zero, hit, z}.
    function automatic logic [14:0] model12(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] d;
        logic        brw;
        d   = a - b;
        brw = (a < b);
        return {brw, (d == 12'h000), (!brw && (d < 12'h200)), d};
    endfunction

    function automatic logic [31:0] obs_s3();
        return 32'({if_s3.borrow, if_s3.zero, if_s3.hit, if_s3.z});
    endfunction

    // Single transfer through the 3-stage pipe; checks latency, z and hit.
    task automatic s3_single(input string tag, input logic [11:0] a, input logic [11:0] b,
                             input logic [11:0] ez, input logic eh);
        int lat;
        if_s3.out_ready = 1'b1;
        if_s3.in_valid  = 1'b1;
        if_s3.x         = a;
        if_s3.y         = b;
        tick();
        if_s3.in_valid = 1'b0;
        lat = 1;
        while (!if_s3.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd3);
        check_eq({tag, "_z"}, 32'(if_s3.z), 32'(ez));
        check_eq({tag, "_hit"}, 32'(if_s3.hit), 32'(eh));
        tick();
    endtask

    // Stream n table pairs into the 3-stage pipe, holding out_ready low for
    // cycles st_lo..st_hi, and check every result against the model in order.
    task automatic run_s3(input string tag, input int n, input int st_lo, input int st_hi);
        int          idx   = 0;
        int          rcv   = 0;
        int          first = -1;
        int          last  = -1;
        logic [11:0] z_prev = '0;
        logic [14:0] e;
        exp_q.delete();
        for (int cyc = 0; cyc < 60 && rcv < n; cyc++) begin
            if_s3.out_ready = !(cyc >= st_lo && cyc <= st_hi);
            if_s3.in_valid  = (idx < n);
            if_s3.x         = (idx < n) ? tx[idx] : 12'h000;
            if_s3.y         = (idx < n) ? ty[idx] : 12'h000;
            #1;
            if (cyc >= st_lo && cyc <= st_hi) begin
                check_eq({tag, "_stall_in_ready"}, 32'(if_s3.in_ready), 32'd0);
                check_eq({tag, "_stall_out_valid"}, 32'(if_s3.out_valid), 32'd1);
                if (cyc > st_lo) check_eq({tag, "_stall_z_hold"}, 32'(if_s3.z), 32'(z_prev));
                z_prev = if_s3.z;
            end
            if (if_s3.out_valid && if_s3.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq({tag, "_unexpected_result"}, 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq({tag, "_result"}, obs_s3(), 32'(e));
                end
                if (first < 0) first = cyc;
                last = cyc;
                rcv++;
            end
            if (if_s3.in_valid && if_s3.in_ready) begin
                exp_q.push_back(model12(tx[idx], ty[idx]));
                idx++;
            end
            tick();
        end
        check_eq({tag, "_count"}, 32'(rcv), 32'(n));
        check_eq({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        if (st_hi < st_lo) check_eq({tag, "_gapless"}, 32'(last - first), 32'(n - 1));
        if_s3.in_valid = 1'b0;
        #1;
        check_eq({tag, "_drained"}, 32'(if_s3.out_valid), 32'd0);
    endtask

    initial begin
        tx[0] = 12'h3FF; ty[0] = 12'h200;
        tx[1] = 12'h400; ty[1] = 12'h200;
        tx[2] = 12'h000; ty[2] = 12'h001;
        tx[3] = 12'hABC; ty[3] = 12'hABC;
        tx[4] = 12'h7FF; ty[4] = 12'h600;
        tx[5] = 12'h123; ty[5] = 12'h100;
        tx[6] = 12'hFFF; ty[6] = 12'h000;
        tx[7] = 12'h200; ty[7] = 12'h3FF;

        if_s1.in_valid  = 1'b0; if_s1.x  = '0; if_s1.y  = '0; if_s1.out_ready  = 1'b0;
        if_s3.in_valid  = 1'b0; if_s3.x  = '0; if_s3.y  = '0; if_s3.out_ready  = 1'b0;
        if_w16.in_valid = 1'b0; if_w16.x = '0; if_w16.y = '0; if_w16.out_ready = 1'b0;

        // Reset state of all three instances.
        rst = 1'b1;
        tick();
        tick();
        check_eq("rst_s1_in_ready", 32'(if_s1.in_ready), 32'd1);
        check_eq("rst_s3_in_ready", 32'(if_s3.in_ready), 32'd1);
        check_eq("rst_s1_outputs", 32'({if_s1.out_valid, if_s1.borrow, if_s1.zero, if_s1.hit, if_s1.z}), 32'd0);
        check_eq("rst_s3_outputs", obs_s3() | 32'(if_s3.out_valid), 32'd0);
        rst = 1'b0;

        // Single-stage: one-cycle latency, basic hit, wrap-around, equality.
        if_s1.out_ready = 1'b1;
        if_s1.in_valid  = 1'b1;
        if_s1.x = 12'h205; if_s1.y = 12'h200;
        tick();
        check_eq("s1_small_valid", 32'(if_s1.out_valid), 32'd1);
        check_eq("s1_small", 32'({if_s1.borrow, if_s1.zero, if_s1.hit, if_s1.z}), 32'h1005);
        if_s1.x = 12'h100; if_s1.y = 12'h200;
        tick();
        check_eq("s1_wrap", 32'({if_s1.borrow, if_s1.zero, if_s1.hit, if_s1.z}), 32'h4F00);
        if_s1.x = 12'hABC; if_s1.y = 12'hABC;
        tick();
        check_eq("s1_equal", 32'({if_s1.borrow, if_s1.zero, if_s1.hit, if_s1.z}), 32'h3000);
        if_s1.in_valid = 1'b0;
        tick();
        check_eq("s1_idle_valid", 32'(if_s1.out_valid), 32'd0);

        // Three stages: window edges and latency.
        s3_single("s3_win_in", 12'h3FF, 12'h200, 12'h1FF, 1'b1);
        s3_single("s3_win_out", 12'h400, 12'h200, 12'h200, 1'b0);

        // Back-to-back stream, then the same stream with a 5-cycle stall.
        run_s3("s3_stream", 8, 100, -1);
        run_s3("s3_backpr", 8, 4, 8);

        // Bubble collapse: only the last stage full, consumer stalled.
        if_s3.out_ready = 1'b0;
        if_s3.in_valid = 1'b1; if_s3.x = 12'h210; if_s3.y = 12'h200;
        tick();
        if_s3.in_valid = 1'b0;
        tick();
        tick();
        check_eq("bub_a_at_out", 32'({if_s3.out_valid, if_s3.z}), 32'h1010);
        if_s3.in_valid = 1'b1; if_s3.x = 12'h250; if_s3.y = 12'h220;
        #1;
        check_eq("bub_b_ready", 32'(if_s3.in_ready), 32'd1);
        tick();
        if_s3.x = 12'h100; if_s3.y = 12'h101;
        #1;
        check_eq("bub_c_ready", 32'(if_s3.in_ready), 32'd1);
        tick();
        if_s3.x = 12'h555; if_s3.y = 12'h111;
        #1;
        check_eq("bub_full_ready", 32'(if_s3.in_ready), 32'd0);
        check_eq("bub_a_held", 32'(if_s3.z), 32'h010);
        if_s3.in_valid  = 1'b0;
        if_s3.out_ready = 1'b1;
        #1;
        check_eq("bub_out_a", obs_s3(), 32'h1010);
        tick();
        check_eq("bub_out_b", obs_s3(), 32'h1030);
        tick();
        check_eq("bub_out_c", obs_s3(), 32'h4FFF);
        tick();
        check_eq("bub_drained", 32'(if_s3.out_valid), 32'd0);

        // 16-bit, 2 stages: reset with two results in flight.
        if_w16.out_ready = 1'b1;
        if_w16.in_valid = 1'b1; if_w16.x = 16'h1234; if_w16.y = 16'h0034;
        tick();
        if_w16.x = 16'h0800; if_w16.y = 16'h0100;
        tick();
        check_eq("w16_pre_reset_valid", 32'(if_w16.out_valid), 32'd1);
        rst = 1'b1;
        if_w16.x = 16'h4444; if_w16.y = 16'h0004;
        tick();
        check_eq("w16_rst_valid", 32'(if_w16.out_valid), 32'd0);
        check_eq("w16_rst_z", 32'(if_w16.z), 32'd0);
        check_eq("w16_rst_in_ready", 32'(if_w16.in_ready), 32'd1);
        rst = 1'b0;
        if_w16.x = 16'hFFFF; if_w16.y = 16'h0001;
        #1;
        check_eq("w16_post_in_ready", 32'(if_w16.in_ready), 32'd1);
        tick();
        if_w16.in_valid = 1'b0;
        begin
            int lat;
            lat = 1;
            while (!if_w16.out_valid && lat < 10) begin
                tick();
                lat++;
            end
            check_eq("w16_latency", 32'(lat), 32'd2);
        end
        check_eq("w16_z", 32'(if_w16.z), 32'hFFFE);
        check_eq("w16_borrow", 32'(if_w16.borrow), 32'd0);
        check_eq("w16_hit", 32'(if_w16.hit), 32'd0);
        tick();
        check_eq("w16_no_stale", 32'(if_w16.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_addr_subtractor_pipe.md
Name: cache_addr_subtractor_pipe

Overview:
- Parametrised, pipelined successor to the instruction-cache address comparator's 12-bit subtractor.
- Computes z = x - y (two's complement: x + ~y + 1) using 4-bit carry-lookahead nibble groups.
- The carry chain is split across STAGES register stages, each with a valid/ready handshake.
- Also emits cache-window flags (hit, zero, borrow), so the cache controller can decide hit/miss without a second compare.

Parameters:
- WIDTH, 12: operand/result width in bits; multiple of 4, 4..32.
- STAGES, 1: number of pipeline register stages; 1..WIDTH/4; must divide WIDTH/4 evenly.
- WINDOW, 512: cache window size in bytes; hit when 0 <= x - y < WINDOW; power of two, 1..2^WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  x/y presented this cycle.
- in_ready  output  1  block accepts x/y this cycle.
- x  input  WIDTH  minuend (fetch address).
- y  input  WIDTH  subtrahend (cache base address).
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer accepts result this cycle.
- z  output  WIDTH  (x - y) mod 2^WIDTH.
- borrow  output  1  1 when x < y unsigned, i.e. final carry-out == 0.
- zero  output  1  z == 0.
- hit  output  1  borrow == 0 and z < WINDOW.

Behaviour:
- Arithmetic
  - Per bit: y_int = ~y; p = x ^ y_int; g = x & y_int; sum = p ^ carry_in.
  - Carry-in to bit 0 is 1.
  - Carries come from 4-bit lookahead groups chained nibble to nibble.
- Pipeline partitioning
  - NPS = WIDTH/4/STAGES nibbles per stage.
  - Stage k resolves nibbles k*NPS .. (k+1)*NPS-1.
  - Stage k registers: its partial z bits, all not-yet-processed x/~y bits, the carry into the next nibble, and a valid bit v[k].
  - Stage 0 captures x, y, and computes nibble group 0 with carry-in 1.
  - The final stage register holds the complete z, borrow, zero and hit; outputs come directly from these registers.
- Latency: a transfer accepted at edge n appears with out_valid=1 after edge n+STAGES-1, i.e. STAGES cycles from in_valid/in_ready to out_valid.
- Handshake and flow
  - Stage k advances when v[k]==0 or the stage downstream of it advances.
  - The final stage advances when out_ready==1 or v[last]==0.
  - in_ready = stage 0 can advance (combinational from out_ready through the stall chain; no skid buffer).
  - Accept occurs when in_valid && in_ready.
  - Bubbles collapse: an empty stage accepts even when downstream is stalled.
  - While stalled, a stage holds all its data; outputs stay stable while out_valid && !out_ready.
  - Throughput: 1 result/cycle when out_ready is held high.
- Simultaneous events: in the same cycle the last stage can hand off its result and stage 0 can accept new data, so a full pipe stays full with no gap.
- Reset
  - reset=1 clears all v[k] and zeroes all data registers at the next edge.
  - Outputs after reset: out_valid=0, z=0, borrow=0, zero=0, hit=0.
  - in_ready=1 during reset.
  - Reset mid-operation discards every in-flight result; no partial output is ever produced.
  - Reset has priority over any accept.
- Boundaries
  - x == y -> z=0, zero=1, borrow=0, hit=1.
  - Wrap-around: x < y gives z = 2^WIDTH - (y - x), borrow=1, hit=0 regardless of z.
  - z == WINDOW-1 -> hit=1; z == WINDOW -> hit=0.
- Combinational loops: none; every stage boundary is registered.

Test Plan:
- WIDTH=12, STAGES=1; x=0x205, y=0x200, out_ready=1 -> one cycle later out_valid=1, z=0x005, borrow=0, zero=0, hit=1.
- WIDTH=12, STAGES=1; x=0x100, y=0x200 -> z=0xF00, borrow=1, hit=0. Then x=y=0xABC -> z=0, zero=1, hit=1.
- WIDTH=12, STAGES=3, WINDOW=512
  - Window edges: x=0x3FF, y=0x200 -> z=0x1FF, hit=1. x=0x400, y=0x200 -> z=0x200, hit=0. Each result arrives 3 cycles after accept.
  - Back-to-back stream of 8 operand pairs with out_ready=1 -> 8 consecutive out_valid cycles, in order, matching a reference model.
- WIDTH=12, STAGES=3
  - Backpressure: out_ready=0 for 5 cycles mid-stream -> in_ready drops once all 3 stages are full; z held stable; no result lost or duplicated after out_ready returns to 1.
  - Bubble collapse: with out_ready=0 and only v[2] set, new inputs fill stages 0 and 1 without loss.
- WIDTH=16, STAGES=2: assert reset with 2 results in flight -> next cycle out_valid=0, z=0, in_ready=1; the next accepted x=0xFFFF, y=0x0001 yields z=0xFFFE, borrow=0 after 2 cycles.
